// File: rtl/eth_rx_da_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eth_rx_da_filter : destination-MAC receive filter with 6-byte delay line     |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module eth_rx_da_filter #(
    parameter int DATA_WIDTH    = 8,
    parameter int MIN_FRAME_LEN = 60,
    parameter int MAX_FRAME_LEN = 1518
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  cfg_filter_en,
    input  logic [47:0]           cfg_local_mac,
    input  logic                  cfg_bcast_en,
    input  logic                  cfg_mcast_en,
    output logic                  stat_rx_pass,
    output logic                  stat_rx_drop_da,
    output logic                  stat_rx_runt,
    output logic                  stat_rx_oversize,
    output logic                  stat_rx_overrun
);

    generate
        if (DATA_WIDTH != 8) begin : g_bad_width
            $error("eth_rx_da_filter: DATA_WIDTH must be 8");
        end
    endgenerate

    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_LEN);
    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LEN);

    typedef enum logic [1:0] {
        S_HDR   = 2'd0,
        S_PASS  = 2'd1,
        S_FLUSH = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] dl_q [6];
    logic [15:0]           len_q;
    logic [15:0]           len_d;
    logic                  uc_q, bc_q, mc_q;
    logic                  uc_d, bc_d, mc_d;
    logic                  err_q, runt_q, ovs_q;
    logic [2:0]            fcnt_q;
    logic [7:0]            mac_byte;
    logic                  first_beat;
    logic                  pass_d, runt_d, ovs_d;

    // Header comparison is evaluated on the live beat so the 6th byte is
    // folded into the decision without an extra cycle.
    always_comb begin
        len_d = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
        case (len_q[2:0])
            3'd0:    mac_byte = cfg_local_mac[47:40];
            3'd1:    mac_byte = cfg_local_mac[39:32];
            3'd2:    mac_byte = cfg_local_mac[31:24];
            3'd3:    mac_byte = cfg_local_mac[23:16];
            3'd4:    mac_byte = cfg_local_mac[15:8];
            default: mac_byte = cfg_local_mac[7:0];
        endcase
        first_beat = (len_q == 16'd0);
        uc_d   = (first_beat | uc_q) & (s_axis_tdata == mac_byte);
        bc_d   = (first_beat | bc_q) & (s_axis_tdata == 8'hFF);
        mc_d   = first_beat ? s_axis_tdata[0] : mc_q;
        pass_d = !cfg_filter_en | uc_d | (bc_d & cfg_bcast_en)
                 | (mc_d & !bc_d & cfg_mcast_en);
        runt_d = (len_d < MIN_LEN);
        ovs_d  = (len_d > MAX_LEN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_HDR;
            for (int k = 0; k < 6; k++) dl_q[k] <= '0;
            len_q            <= '0;
            uc_q             <= 1'b0;
            bc_q             <= 1'b0;
            mc_q             <= 1'b0;
            err_q            <= 1'b0;
            runt_q           <= 1'b0;
            ovs_q            <= 1'b0;
            fcnt_q           <= '0;
            m_axis_tdata     <= '0;
            m_axis_tvalid    <= 1'b0;
            m_axis_tlast     <= 1'b0;
            m_axis_tuser     <= 1'b0;
            stat_rx_pass     <= 1'b0;
            stat_rx_drop_da  <= 1'b0;
            stat_rx_runt     <= 1'b0;
            stat_rx_oversize <= 1'b0;
            stat_rx_overrun  <= 1'b0;
        end else begin
            m_axis_tvalid    <= 1'b0;
            m_axis_tlast     <= 1'b0;
            m_axis_tuser     <= 1'b0;
            stat_rx_pass     <= 1'b0;
            stat_rx_drop_da  <= 1'b0;
            stat_rx_runt     <= 1'b0;
            stat_rx_oversize <= 1'b0;
            stat_rx_overrun  <= 1'b0;

            case (state_q)
                S_HDR: begin
                    if (s_axis_tvalid) begin
                        for (int k = 5; k > 0; k--) dl_q[k] <= dl_q[k-1];
                        dl_q[0] <= s_axis_tdata;
                        uc_q    <= uc_d;
                        bc_q    <= bc_d;
                        mc_q    <= mc_d;
                        if (len_q == 16'd5) begin
                            if (pass_d) begin
                                if (s_axis_tlast) begin
                                    err_q   <= s_axis_tuser | runt_d | ovs_d;
                                    runt_q  <= runt_d;
                                    ovs_q   <= ovs_d;
                                    fcnt_q  <= '0;
                                    len_q   <= '0;
                                    state_q <= S_FLUSH;
                                end else begin
                                    len_q   <= len_d;
                                    state_q <= S_PASS;
                                end
                            end else begin
                                stat_rx_drop_da <= 1'b1;
                                if (s_axis_tlast) begin
                                    len_q   <= '0;
                                    state_q <= S_HDR;
                                end else begin
                                    len_q   <= len_d;
                                    state_q <= S_DROP;
                                end
                            end
                        end else if (s_axis_tlast) begin
                            // Shorter than a DA: nothing was emitted, so just count it.
                            stat_rx_runt <= 1'b1;
                            len_q        <= '0;
                        end else begin
                            len_q <= len_d;
                        end
                    end
                end

                S_PASS: begin
                    if (s_axis_tvalid) begin
                        for (int k = 5; k > 0; k--) dl_q[k] <= dl_q[k-1];
                        dl_q[0]       <= s_axis_tdata;
                        m_axis_tdata  <= dl_q[5];
                        m_axis_tvalid <= 1'b1;
                        if (s_axis_tlast) begin
                            err_q   <= s_axis_tuser | runt_d | ovs_d;
                            runt_q  <= runt_d;
                            ovs_q   <= ovs_d;
                            fcnt_q  <= '0;
                            len_q   <= '0;
                            state_q <= S_FLUSH;
                        end else begin
                            len_q <= len_d;
                        end
                    end
                end

                S_FLUSH: begin
                    for (int k = 5; k > 0; k--) dl_q[k] <= dl_q[k-1];
                    dl_q[0]         <= '0;
                    m_axis_tdata    <= dl_q[5];
                    m_axis_tvalid   <= 1'b1;
                    fcnt_q          <= fcnt_q + 3'd1;
                    stat_rx_overrun <= s_axis_tvalid;
                    if (fcnt_q == 3'd5) begin
                        m_axis_tlast     <= 1'b1;
                        m_axis_tuser     <= err_q;
                        stat_rx_pass     <= 1'b1;
                        stat_rx_runt     <= runt_q;
                        stat_rx_oversize <= ovs_q;
                        state_q          <= S_HDR;
                    end
                end

                default: begin
                    if (s_axis_tvalid) begin
                        if (s_axis_tlast) begin
                            len_q   <= '0;
                            state_q <= S_HDR;
                        end else begin
                            len_q <= len_d;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_da_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_eth_rx_da_filter : table-driven self-checking bench for the DA filter     |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_eth_rx_da_filter;

    localparam logic [47:0] C_MAC  = 48'h02_00_00_00_00_01;
    localparam logic [47:0] C_MAC2 = 48'h02_00_00_00_00_02;
    localparam logic [47:0] C_BC   = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] C_MC   = 48'h01_00_5E_00_00_01;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic        cfg_filter_en = 1'b1;
    logic [47:0] cfg_local_mac = C_MAC;
    logic        cfg_bcast_en = 1'b0;
    logic        cfg_mcast_en = 1'b0;
    logic        stat_rx_pass, stat_rx_drop_da, stat_rx_runt, stat_rx_oversize, stat_rx_overrun;

    eth_rx_da_filter #(.DATA_WIDTH(8), .MIN_FRAME_LEN(60), .MAX_FRAME_LEN(1518)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .cfg_filter_en(cfg_filter_en), .cfg_local_mac(cfg_local_mac),
        .cfg_bcast_en(cfg_bcast_en), .cfg_mcast_en(cfg_mcast_en),
        .stat_rx_pass(stat_rx_pass), .stat_rx_drop_da(stat_rx_drop_da),
        .stat_rx_runt(stat_rx_runt), .stat_rx_oversize(stat_rx_oversize),
        .stat_rx_overrun(stat_rx_overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Output monitor, sampled on the falling edge.
    int         ncyc = 0;
    int         in_last_cyc = 0;
    logic [7:0] out_q[$];
    logic [7:0] exp_q[$];
    int         tlast_cnt, stray_tuser, lat;
    logic       last_tuser;
    int         pass_cnt, drop_cnt, runt_cnt, ovs_cnt, ovr_cnt;

    always @(negedge clk) begin
        ncyc++;
        if (s_axis_tvalid && s_axis_tlast) in_last_cyc = ncyc;
        if (m_axis_tvalid) begin
            out_q.push_back(m_axis_tdata);
            if (m_axis_tlast) begin
                tlast_cnt++;
                last_tuser = m_axis_tuser;
                lat = ncyc - in_last_cyc;
            end
        end
        if (m_axis_tuser && !(m_axis_tvalid && m_axis_tlast)) stray_tuser++;
        pass_cnt += int'(stat_rx_pass);
        drop_cnt += int'(stat_rx_drop_da);
        runt_cnt += int'(stat_rx_runt);
        ovs_cnt  += int'(stat_rx_oversize);
        ovr_cnt  += int'(stat_rx_overrun);
    end

    task automatic clear_mon();
        out_q.delete();
        exp_q.delete();
        tlast_cnt = 0; stray_tuser = 0; lat = -1; last_tuser = 1'b0;
        pass_cnt = 0; drop_cnt = 0; runt_cnt = 0; ovs_cnt = 0; ovr_cnt = 0;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [47:0] da, input int i);
        logic [7:0] b;
        if (i < 6) b = da[47-8*i -: 8];
        else       b = 8'((i * 7 + 3) & 255);
        return b;
    endfunction

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Drives bytes [from, to) of a frame; tlast on byte len-1.
    task automatic send_bytes(input logic [47:0] da, input int from, input int to,
                              input int len, input bit tu, input bit gap);
        for (int i = from; i < to; i++) begin
            s_axis_tdata  = byte_at(da, i);
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (i == len - 1);
            s_axis_tuser  = tu && (i == len - 1);
            @(posedge clk); #1;
            if (gap) begin
                s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
                @(posedge clk); #1;
            end
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    endtask

    task automatic expect_frame(input logic [47:0] da, input int len);
        for (int i = 0; i < len; i++) exp_q.push_back(byte_at(da, i));
    endtask

    function automatic int data_errs();
        int n = 0;
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
            if (out_q[i] !== exp_q[i]) n++;
        return n;
    endfunction

    typedef struct {
        string       name;
        logic [47:0] da;
        int          len;
        bit          tuser;
        bit          flt, bc, mc, gap;
        bit          exp_pass, exp_tuser, exp_runt, exp_ovs, exp_drop;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string nm, logic [47:0] da, int len, bit tu, bit flt,
                                bit bc, bit mc, bit gap, bit p, bit etu, bit r, bit o, bit d);
        vec_t v;
        v.name = nm; v.da = da; v.len = len; v.tuser = tu;
        v.flt = flt; v.bc = bc; v.mc = mc; v.gap = gap;
        v.exp_pass = p; v.exp_tuser = etu; v.exp_runt = r; v.exp_ovs = o; v.exp_drop = d;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //             name          da      len  tu flt bc mc gap  pass tu runt ovs drop
        tbl.push_back(mk("uc_match",   C_MAC,  64,  0, 1, 0, 0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk("uc_miss",    C_MAC2, 64,  0, 1, 0, 0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk("uc_after",   C_MAC,  64,  0, 1, 0, 0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk("bc_off",     C_BC,   64,  0, 1, 0, 0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk("bc_mc_only", C_BC,   64,  0, 1, 0, 1, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk("bc_on",      C_BC,   64,  0, 1, 1, 0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk("mc_on",      C_MC,   64,  0, 1, 0, 1, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk("mc_off",     C_MC,   64,  0, 1, 0, 0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk("promisc",    C_MAC2, 64,  0, 0, 0, 0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk("runt40",     C_MAC,  40,  0, 1, 0, 0, 0,  1, 1, 1, 0, 0));
        tbl.push_back(mk("runt6",      C_MAC,  6,   0, 1, 0, 0, 0,  1, 1, 1, 0, 0));
        tbl.push_back(mk("runt5",      C_MAC,  5,   0, 1, 0, 0, 0,  0, 0, 1, 0, 0));
        tbl.push_back(mk("runt4",      C_MAC,  4,   0, 1, 0, 0, 0,  0, 0, 1, 0, 0));
        tbl.push_back(mk("promisc3",   C_MAC2, 3,   0, 0, 0, 0, 0,  0, 0, 1, 0, 0));
        tbl.push_back(mk("miss6",      C_MAC2, 6,   0, 1, 0, 0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk("min60",      C_MAC,  60,  0, 1, 0, 0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk("bad_fcs",    C_MAC,  64,  1, 1, 0, 0, 0,  1, 1, 0, 0, 0));
        tbl.push_back(mk("max1518",    C_MAC,  1518,0, 1, 0, 0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk("over1519",   C_MAC,  1519,0, 1, 0, 0, 0,  1, 1, 0, 1, 0));
        tbl.push_back(mk("over1600",   C_MAC,  1600,0, 1, 0, 0, 0,  1, 1, 0, 1, 0));
        tbl.push_back(mk("mii",        C_MAC,  64,  0, 1, 0, 0, 1,  1, 0, 0, 0, 0));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
              stat_rx_pass, stat_rx_drop_da, stat_rx_runt, stat_rx_oversize, stat_rx_overrun}, 0);
        rst_n = 1'b1;
        idle(2);
        check("idle_tvalid", m_axis_tvalid, 0);

        foreach (tbl[n]) begin
            cfg_filter_en = tbl[n].flt;
            cfg_bcast_en  = tbl[n].bc;
            cfg_mcast_en  = tbl[n].mc;
            clear_mon();
            if (tbl[n].exp_pass) expect_frame(tbl[n].da, tbl[n].len);
            send_bytes(tbl[n].da, 0, tbl[n].len, tbl[n].len, tbl[n].tuser, tbl[n].gap);
            idle(12);
            check({tbl[n].name, "_beats"}, out_q.size(), tbl[n].exp_pass ? tbl[n].len : 0);
            check({tbl[n].name, "_data"}, data_errs(), 0);
            check({tbl[n].name, "_tlast"}, tlast_cnt, tbl[n].exp_pass ? 1 : 0);
            check({tbl[n].name, "_tuser"}, last_tuser, tbl[n].exp_tuser);
            check({tbl[n].name, "_stray_tuser"}, stray_tuser, 0);
            if (tbl[n].exp_pass) check({tbl[n].name, "_latency"}, lat, 7);
            check({tbl[n].name, "_stat_pass"}, pass_cnt, tbl[n].exp_pass ? 1 : 0);
            check({tbl[n].name, "_stat_drop"}, drop_cnt, tbl[n].exp_drop ? 1 : 0);
            check({tbl[n].name, "_stat_runt"}, runt_cnt, tbl[n].exp_runt ? 1 : 0);
            check({tbl[n].name, "_stat_ovs"}, ovs_cnt, tbl[n].exp_ovs ? 1 : 0);
            check({tbl[n].name, "_stat_ovr"}, ovr_cnt, 0);
        end

        cfg_filter_en = 1'b1; cfg_bcast_en = 1'b0; cfg_mcast_en = 1'b0;

        // Beats arriving during FLUSH are discarded and counted as overruns
        clear_mon();
        expect_frame(C_MAC, 64);
        send_bytes(C_MAC, 0, 64, 64, 1'b0, 1'b0);
        s_axis_tdata = 8'hAA; s_axis_tvalid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        idle(12);
        check("ovr_beats", out_q.size(), 64);
        check("ovr_data", data_errs(), 0);
        check("ovr_stat_ovr", ovr_cnt, 2);
        check("ovr_stat_pass", pass_cnt, 1);

        // Reset in the middle of PASS, then the remainder is parsed as a header
        clear_mon();
        send_bytes(C_MAC, 0, 30, 64, 1'b0, 1'b0);
        check("mid_tvalid_before", m_axis_tvalid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", {m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
              stat_rx_pass, stat_rx_drop_da, stat_rx_runt, stat_rx_oversize, stat_rx_overrun}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        clear_mon();
        send_bytes(C_MAC, 30, 64, 64, 1'b0, 1'b0);
        idle(12);
        check("remainder_beats", out_q.size(), 0);
        check("remainder_drop", drop_cnt, 1);
        check("remainder_tlast", tlast_cnt, 0);

        clear_mon();
        expect_frame(C_MAC, 64);
        send_bytes(C_MAC, 0, 64, 64, 1'b0, 1'b0);
        idle(12);
        check("post_reset_beats", out_q.size(), 64);
        check("post_reset_data", data_errs(), 0);
        check("post_reset_pass", pass_cnt, 1);
        check("post_reset_latency", lat, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
